// File: rtl/ring_rotate_ctrl.sv
// Sequencer for a rotating load/clear ring register: loads a pattern, lets the ring rotate
// a commanded number of clocks, captures the result and flags a mismatch with the expected rotation.
module ring_rotate_ctrl #(
  parameter int WIDTH  = 16,
  parameter int STEP_W = 4
) (
  input  logic              Clk,
  input  logic              Clr,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic [WIDTH-1:0]  i_cmd_pat,
  input  logic [STEP_W-1:0] i_cmd_steps,
  output logic              o_rc_ld,
  output logic [WIDTH-1:0]  o_rc_in,
  input  logic [WIDTH-1:0]  i_rc_out,
  output logic              o_res_valid,
  input  logic              i_res_ready,
  output logic [WIDTH-1:0]  o_res_data,
  output logic              o_res_err,
  output logic [2:0]        o_dbg_state
);

  // Handshakes: a transfer happens on a posedge where valid and ready are both high;
  // valid never waits on ready, and the command/result fields are only sampled on a transfer.

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_ROT  = 3'd2,
    S_CAPT = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_armed;
  logic [WIDTH-1:0]    r_pat;
  logic [WIDTH-1:0]    r_exp;
  logic [STEP_W-1:0]   r_cnt;
  logic [WIDTH-1:0]    r_hold;
  logic [WIDTH-1:0]    r_res_data;
  logic                r_res_err;
  logic                w_accept;
  logic [2*WIDTH-1:0]  w_dbl;

  // Rotate-right by shifting a doubled copy; steps=0 yields the pattern itself.
  assign w_dbl    = {i_cmd_pat, i_cmd_pat} >> i_cmd_steps;
  assign w_accept = o_cmd_ready & i_cmd_valid;

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = S_LOAD;
      S_LOAD: w_next = (r_cnt == '0) ? S_CAPT : S_ROT;
      S_ROT:  if (r_cnt == STEP_W'(1)) w_next = S_CAPT;
      S_CAPT: w_next = S_DONE;
      S_DONE: if (i_res_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // r_armed keeps every strobe low from reset until the first clock after Clr drops.
  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      r_armed    <= 1'b0;
      r_pat      <= '0;
      r_exp      <= '0;
      r_cnt      <= '0;
      r_hold     <= '0;
      r_res_data <= '0;
      r_res_err  <= 1'b0;
    end else begin
      r_armed <= 1'b1;
      if (w_accept) begin
        r_pat <= i_cmd_pat;
        r_exp <= w_dbl[WIDTH-1:0];
        r_cnt <= i_cmd_steps;
      end
      if (r_state == S_ROT) r_cnt <= r_cnt - STEP_W'(1);
      if (r_state == S_CAPT) begin
        r_res_data <= i_rc_out;
        r_res_err  <= (i_rc_out != r_exp);
        r_hold     <= i_rc_out;
      end
    end
  end

  always_comb begin
    o_cmd_ready = r_armed && (r_state == S_IDLE);
    o_rc_ld     = r_armed && (r_state != S_ROT);
    o_res_valid = (r_state == S_DONE);
    o_rc_in     = r_hold;
    case (r_state)
      S_LOAD:  o_rc_in = r_pat;
      S_CAPT:  o_rc_in = i_rc_out;
      default: o_rc_in = r_hold;
    endcase
  end

  assign o_res_data  = r_res_data;
  assign o_res_err   = r_res_err;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_ring_rotate_ctrl.sv
// Directed bench for ring_rotate_ctrl with a behavioural ring register that can be told
// to swallow one rotation edge.
module tb_ring_rotate_ctrl;

  logic        Clk;
  logic        Clr;
  logic        i_cmd_valid;
  logic        o_cmd_ready;
  logic [15:0] i_cmd_pat;
  logic [3:0]  i_cmd_steps;
  logic        o_rc_ld;
  logic [15:0] o_rc_in;
  logic [15:0] ring;
  logic        o_res_valid;
  logic        i_res_ready;
  logic [15:0] o_res_data;
  logic        o_res_err;
  logic [2:0]  o_dbg_state;

  logic        drop_req;
  logic        dropped;
  int          n_checks;
  int          n_errs;
  logic [15:0] exp_q[$];

  ring_rotate_ctrl #(.WIDTH(16), .STEP_W(4)) dut (
    .Clk(Clk), .Clr(Clr),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_pat(i_cmd_pat), .i_cmd_steps(i_cmd_steps),
    .o_rc_ld(o_rc_ld), .o_rc_in(o_rc_in), .i_rc_out(ring),
    .o_res_valid(o_res_valid), .i_res_ready(i_res_ready),
    .o_res_data(o_res_data), .o_res_err(o_res_err),
    .o_dbg_state(o_dbg_state)
  );

  // clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // ring register model: rotate right by one when not loading
  always @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      ring    <= '0;
      dropped <= 1'b0;
    end else if (o_rc_ld) begin
      ring <= o_rc_in;
    end else if (drop_req && !dropped) begin
      dropped <= 1'b1;
    end else begin
      ring <= {ring[0], ring[15:1]};
    end
    if (!Clr && !drop_req) dropped <= 1'b0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver: issue one command and wait for the result, measuring latency and Ld=0 cycles
  task automatic run_cmd(input logic [15:0] pat, input logic [3:0] steps,
                         input logic [15:0] exp_data, input logic exp_err,
                         input logic drop);
    int w;
    int n;
    int ld0;
    logic [15:0] exp_v;
    w = 0;
    @(negedge Clk);
    while (!o_cmd_ready && w < 20) begin
      @(negedge Clk);
      w++;
    end
    chk("cmd_ready_before_cmd", o_cmd_ready, 1);
    exp_q.push_back(exp_data);
    i_cmd_valid = 1'b1;
    i_cmd_pat   = pat;
    i_cmd_steps = steps;
    @(posedge Clk);
    #1;
    i_cmd_valid = 1'b0;
    drop_req    = drop;
    n   = 0;
    ld0 = 0;
    while (n < 40) begin
      @(negedge Clk);
      if (o_res_valid) break;
      if (!o_rc_ld) ld0++;
      @(posedge Clk);
      n++;
    end
    drop_req = 1'b0;
    exp_v = exp_q.pop_front();
    chk("latency", n, 32'(steps) + 2);
    chk("ld0_cycles", ld0, 32'(steps));
    chk("res_valid", o_res_valid, 1);
    chk("res_data", o_res_data, exp_v);
    chk("res_err", o_res_err, exp_err);
    chk("ring_frozen", ring, exp_v);
  endtask

  task automatic handshake();
    i_res_ready = 1'b1;
    @(posedge Clk);
    #1;
    i_res_ready = 1'b0;
    @(negedge Clk);
    chk("res_valid_drop", o_res_valid, 0);
    chk("cmd_ready_after", o_cmd_ready, 1);
  endtask

  initial begin
    bit saw;
    n_checks    = 0;
    n_errs      = 0;
    Clr         = 1'b1;
    i_cmd_valid = 1'b0;
    i_cmd_pat   = '0;
    i_cmd_steps = '0;
    i_res_ready = 1'b0;
    drop_req    = 1'b0;

    #12;
    chk("rst_cmd_ready", o_cmd_ready, 0);
    chk("rst_rc_ld", o_rc_ld, 0);
    chk("rst_rc_in", o_rc_in, 0);
    chk("rst_res_valid", o_res_valid, 0);
    chk("rst_res_data", o_res_data, 0);
    chk("rst_res_err", o_res_err, 0);
    chk("rst_state", o_dbg_state, 0);
    @(negedge Clk);
    Clr = 1'b0;
    @(posedge Clk);
    @(negedge Clk);
    chk("post_rst_cmd_ready", o_cmd_ready, 1);
    chk("post_rst_rc_ld", o_rc_ld, 1);
    chk("post_rst_rc_in", o_rc_in, 0);

    run_cmd(16'h0001, 4'd1, 16'h8000, 1'b0, 1'b0);
    handshake();
    run_cmd(16'h00F0, 4'd0, 16'h00F0, 1'b0, 1'b0);
    handshake();
    run_cmd(16'hA5C3, 4'd15, 16'h4B87, 1'b0, 1'b0);

    // stall the result while a stray command is offered
    i_cmd_valid = 1'b1;
    i_cmd_pat   = 16'hFFFF;
    i_cmd_steps = 4'd2;
    repeat (10) @(negedge Clk);
    chk("stall_ring", ring, 16'h4B87);
    chk("stall_res_valid", o_res_valid, 1);
    chk("stall_cmd_ready", o_cmd_ready, 0);
    chk("stall_state", o_dbg_state, 4);
    chk("stall_res_data", o_res_data, 16'h4B87);
    i_cmd_valid = 1'b0;
    handshake();
    chk("idle_rc_in_hold", o_rc_in, 16'h4B87);

    run_cmd(16'h00FF, 4'd8, 16'hFF00, 1'b0, 1'b0);
    handshake();
    // ring swallows one edge: only two of three rotations happen
    run_cmd(16'h0001, 4'd3, 16'h4000, 1'b1, 1'b0 | 1'b1);
    handshake();

    // abort mid-rotation
    @(negedge Clk);
    i_cmd_valid = 1'b1;
    i_cmd_pat   = 16'hFF00;
    i_cmd_steps = 4'd10;
    @(posedge Clk);
    #1;
    i_cmd_valid = 1'b0;
    repeat (4) @(negedge Clk);
    chk("abort_in_rot", o_dbg_state, 2);
    #2;
    Clr = 1'b1;
    #1;
    chk("abort_cmd_ready", o_cmd_ready, 0);
    chk("abort_rc_ld", o_rc_ld, 0);
    chk("abort_rc_in", o_rc_in, 0);
    chk("abort_res_valid", o_res_valid, 0);
    chk("abort_res_data", o_res_data, 0);
    chk("abort_res_err", o_res_err, 0);
    chk("abort_state", o_dbg_state, 0);
    @(negedge Clk);
    Clr = 1'b0;
    saw = 1'b0;
    repeat (15) begin
      @(negedge Clk);
      if (o_res_valid) saw = 1'b1;
    end
    chk("abort_no_result", saw, 0);
    chk("abort_cmd_ready_back", o_cmd_ready, 1);

    run_cmd(16'h1234, 4'd4, 16'h4123, 1'b0, 1'b0);
    handshake();

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
